// File: rtl/axi4_wch_arbiter.sv
// axi4_wch_arbiter
//   Two-port AXI4 write-path arbiter. AW requests from two slave ports are
//   arbitrated round-robin and forwarded through a registered master AW
//   port. Each grant index goes into a small order FIFO. The head of that
//   FIFO steers the W channel from the matching port until WLAST, which
//   keeps W beats in AW grant order with no write interleaving.
//
//   Optional feature macro: AXI4_WARB_STATS_EN adds per-port grant counters
//   (grant_cnt0/grant_cnt1) and a synchronous clear input (stats_clr).
//
// Ports
//   axi4_aclk, axi4_arst          clock, asynchronous active-high reset
//   s_axi4_aw*                    packed 2-port AW slave side (port0 in LSBs)
//   m_axi4_aw*                    registered AW master side
//   s_axi4_w*                     packed 2-port W slave side (port0 in LSBs)
//   m_axi4_w*                     W master side (combinational mux)
//   stats_clr, grant_cnt0/1       present only with AXI4_WARB_STATS_EN
module axi4_wch_arbiter #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_USER_WIDTH = 2,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_ID_WIDTH   = 4,
  parameter int C_ORDER_DEPTH    = 4
) (
  input  logic                            axi4_aclk,
  input  logic                            axi4_arst,
`ifdef AXI4_WARB_STATS_EN
  input  logic                            stats_clr,
  output logic [31:0]                     grant_cnt0,
  output logic [31:0]                     grant_cnt1,
`endif
  input  logic [2*C_AXI_ADDR_WIDTH-1:0]   s_axi4_awaddr,
  input  logic [2*C_AXI_ID_WIDTH-1:0]     s_axi4_awid,
  input  logic [2*8-1:0]                  s_axi4_awlen,
  input  logic [1:0]                      s_axi4_awvalid,
  output logic [1:0]                      s_axi4_awready,
  output logic [C_AXI_ADDR_WIDTH-1:0]     m_axi4_awaddr,
  output logic [C_AXI_ID_WIDTH-1:0]       m_axi4_awid,
  output logic [7:0]                      m_axi4_awlen,
  output logic                            m_axi4_awvalid,
  input  logic                            m_axi4_awready,
  input  logic [2*C_AXI_DATA_WIDTH-1:0]   s_axi4_wdata,
  input  logic [2*C_AXI_DATA_WIDTH/8-1:0] s_axi4_wstrb,
  input  logic [1:0]                      s_axi4_wlast,
  input  logic [2*C_AXI_USER_WIDTH-1:0]   s_axi4_wuser,
  input  logic [1:0]                      s_axi4_wvalid,
  output logic [1:0]                      s_axi4_wready,
  output logic [C_AXI_DATA_WIDTH-1:0]     m_axi4_wdata,
  output logic [C_AXI_DATA_WIDTH/8-1:0]   m_axi4_wstrb,
  output logic                            m_axi4_wlast,
  output logic [C_AXI_USER_WIDTH-1:0]     m_axi4_wuser,
  output logic                            m_axi4_wvalid,
  input  logic                            m_axi4_wready
);

  localparam int STRB_W = C_AXI_DATA_WIDTH / 8;
  localparam int PTR_W  = $clog2(C_ORDER_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(C_ORDER_DEPTH);

  typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;

  // Per-port views of the packed slave buses
  logic [C_AXI_ADDR_WIDTH-1:0] awaddr_arr [2];
  logic [C_AXI_ID_WIDTH-1:0]   awid_arr   [2];
  logic [7:0]                  awlen_arr  [2];
  logic [C_AXI_DATA_WIDTH-1:0] wdata_arr  [2];
  logic [STRB_W-1:0]           wstrb_arr  [2];
  logic [C_AXI_USER_WIDTH-1:0] wuser_arr  [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    assign awaddr_arr[gi] = s_axi4_awaddr[gi*C_AXI_ADDR_WIDTH +: C_AXI_ADDR_WIDTH];
    assign awid_arr[gi]   = s_axi4_awid[gi*C_AXI_ID_WIDTH +: C_AXI_ID_WIDTH];
    assign awlen_arr[gi]  = s_axi4_awlen[gi*8 +: 8];
    assign wdata_arr[gi]  = s_axi4_wdata[gi*C_AXI_DATA_WIDTH +: C_AXI_DATA_WIDTH];
    assign wstrb_arr[gi]  = s_axi4_wstrb[gi*STRB_W +: STRB_W];
    assign wuser_arr[gi]  = s_axi4_wuser[gi*C_AXI_USER_WIDTH +: C_AXI_USER_WIDTH];
  end

  state_t                      state_reg, state_next;
  logic                        rr_ptr_reg;
  logic                        winner;
  logic                        grant;
  logic [C_AXI_ADDR_WIDTH-1:0] awaddr_reg;
  logic [C_AXI_ID_WIDTH-1:0]   awid_reg;
  logic [7:0]                  awlen_reg;

  logic                        order_mem_reg [C_ORDER_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]              count_reg;
  logic                        fifo_full, fifo_empty;
  logic                        sel;
  logic                        pop;

  assign fifo_full  = (count_reg == DEPTH_CNT);
  assign fifo_empty = (count_reg == '0);
  assign sel        = order_mem_reg[rd_ptr_reg];
  assign winner     = s_axi4_awvalid[rr_ptr_reg] ? rr_ptr_reg : ~rr_ptr_reg;

  // ---------------- AW FSM: state register ----------------
  always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
    if (axi4_arst) state_reg <= ST_IDLE;
    else           state_reg <= state_next;
  end

  // ---------------- AW FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (grant) state_next = ST_HOLD;
      ST_HOLD: if (m_axi4_awready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- AW FSM: outputs ----------------
  // The ready pulse is masked while reset is held so that a requester
  // cannot see a handshake that the cleared state will never honour.
  always_comb begin
    grant          = 1'b0;
    s_axi4_awready = 2'b00;
    m_axi4_awvalid = (state_reg == ST_HOLD);
    if (state_reg == ST_IDLE && (|s_axi4_awvalid) && !fifo_full && !axi4_arst) begin
      grant                  = 1'b1;
      s_axi4_awready[winner] = 1'b1;
    end
  end

  assign m_axi4_awaddr = awaddr_reg;
  assign m_axi4_awid   = awid_reg;
  assign m_axi4_awlen  = awlen_reg;

  // AW payload capture and round-robin pointer
  always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
    if (axi4_arst) begin
      awaddr_reg <= '0;
      awid_reg   <= '0;
      awlen_reg  <= '0;
      rr_ptr_reg <= 1'b0;
    end else if (grant) begin
      awaddr_reg <= awaddr_arr[winner];
      awid_reg   <= awid_arr[winner];
      awlen_reg  <= awlen_arr[winner];
      rr_ptr_reg <= ~winner;
    end
  end

  // ---------------- Order FIFO ----------------
  // Full is judged before any pop of the same cycle, so a pop never frees a
  // slot for a same-cycle push; grant stays independent of the W handshake.
  always_ff @(posedge axi4_aclk) begin
    if (grant) order_mem_reg[wr_ptr_reg] <= winner;
  end

  always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
    if (axi4_arst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (grant) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({grant, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------- W steering ----------------
  always_comb begin
    m_axi4_wvalid = 1'b0;
    m_axi4_wdata  = '0;
    m_axi4_wstrb  = '0;
    m_axi4_wlast  = 1'b0;
    m_axi4_wuser  = '0;
    s_axi4_wready = 2'b00;
    if (!fifo_empty) begin
      m_axi4_wvalid      = s_axi4_wvalid[sel];
      m_axi4_wdata       = wdata_arr[sel];
      m_axi4_wstrb       = wstrb_arr[sel];
      m_axi4_wlast       = s_axi4_wlast[sel];
      m_axi4_wuser       = wuser_arr[sel];
      s_axi4_wready[sel] = m_axi4_wready;
    end
  end

  assign pop = m_axi4_wvalid & m_axi4_wready & m_axi4_wlast;

`ifdef AXI4_WARB_STATS_EN
  // Saturating grant counters; clear wins over a same-cycle increment.
  logic [31:0] grant_cnt_reg [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_stats
    always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
      if (axi4_arst) begin
        grant_cnt_reg[gi] <= '0;
      end else if (stats_clr) begin
        grant_cnt_reg[gi] <= '0;
      end else if (grant && (winner == gi[0]) && (grant_cnt_reg[gi] != 32'hFFFF_FFFF)) begin
        grant_cnt_reg[gi] <= grant_cnt_reg[gi] + 32'd1;
      end
    end
  end

  assign grant_cnt0 = grant_cnt_reg[0];
  assign grant_cnt1 = grant_cnt_reg[1];
`endif

endmodule

// File: tb/tb_axi4_wch_arbiter.sv
// Directed bench for axi4_wch_arbiter (default parameters).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_axi4_wch_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] awaddr;
  logic [7:0]  awid;
  logic [15:0] awlen;
  logic [1:0]  awvalid;
  logic [1:0]  awready;
  logic [31:0] m_awaddr;
  logic [3:0]  m_awid;
  logic [7:0]  m_awlen;
  logic        m_awvalid;
  logic        m_awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic [1:0]  wlast;
  logic [3:0]  wuser;
  logic [1:0]  wvalid;
  logic [1:0]  wready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast;
  logic [1:0]  m_wuser;
  logic        m_wvalid;
  logic        m_wready;
`ifdef AXI4_WARB_STATS_EN
  logic        stats_clr;
  logic [31:0] grant_cnt0, grant_cnt1;
  int          granted;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  axi4_wch_arbiter dut (
    .axi4_aclk      (clk),
    .axi4_arst      (rst),
`ifdef AXI4_WARB_STATS_EN
    .stats_clr      (stats_clr),
    .grant_cnt0     (grant_cnt0),
    .grant_cnt1     (grant_cnt1),
`endif
    .s_axi4_awaddr  (awaddr),
    .s_axi4_awid    (awid),
    .s_axi4_awlen   (awlen),
    .s_axi4_awvalid (awvalid),
    .s_axi4_awready (awready),
    .m_axi4_awaddr  (m_awaddr),
    .m_axi4_awid    (m_awid),
    .m_axi4_awlen   (m_awlen),
    .m_axi4_awvalid (m_awvalid),
    .m_axi4_awready (m_awready),
    .s_axi4_wdata   (wdata),
    .s_axi4_wstrb   (wstrb),
    .s_axi4_wlast   (wlast),
    .s_axi4_wuser   (wuser),
    .s_axi4_wvalid  (wvalid),
    .s_axi4_wready  (wready),
    .m_axi4_wdata   (m_wdata),
    .m_axi4_wstrb   (m_wstrb),
    .m_axi4_wlast   (m_wlast),
    .m_axi4_wuser   (m_wuser),
    .m_axi4_wvalid  (m_wvalid),
    .m_axi4_wready  (m_wready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    rst       = 1'b1;
    awaddr    = {32'h2000_0000, 32'h1000_0000};
    awid      = {4'h5, 4'h3};
    awlen     = 16'h0000;
    awvalid   = 2'b00;
    m_awready = 1'b1;
    wdata     = '0;
    wstrb     = {4'hC, 4'h3};
    wlast     = 2'b00;
    wuser     = {2'b01, 2'b10};
    wvalid    = 2'b00;
    m_wready  = 1'b1;
`ifdef AXI4_WARB_STATS_EN
    stats_clr = 1'b0;
    granted   = 0;
`endif

    // ---- reset state ----
    @(negedge clk); #1;
    check("rst_m_awvalid", m_awvalid, 0);
    check("rst_m_awaddr", m_awaddr, 0);
    check("rst_s_awready", awready, 0);
    check("rst_m_wvalid", m_wvalid, 0);
    check("rst_s_wready", wready, 0);

    // ---- 1: both ports request, grants alternate 0,1,0,1 ----
    @(negedge clk); rst = 1'b0; awvalid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t1_grant", awready, (i % 2) ? 2'b10 : 2'b01);
      check("t1_awvalid_idle", m_awvalid, 0);
      @(negedge clk);
      if (i == 3) awvalid = 2'b00;
      #1;
      check("t1_m_awvalid", m_awvalid, 1);
      check("t1_m_awid", m_awid, (i % 2) ? 4'h5 : 4'h3);
      check("t1_m_awaddr", m_awaddr, (i % 2) ? 32'h2000_0000 : 32'h1000_0000);
      check("t1_hold_no_grant", awready, 0);
      @(negedge clk);
    end
    // drain single-beat bursts in grant order, back to back
    wvalid = 2'b11; wlast = 2'b11; wdata = {32'h0000_00B1, 32'h0000_00A0};
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t1_w_data", m_wdata, (i % 2) ? 32'hB1 : 32'hA0);
      check("t1_w_strb", m_wstrb, (i % 2) ? 4'hC : 4'h3);
      check("t1_s_wready", wready, (i % 2) ? 2'b10 : 2'b01);
      @(negedge clk);
    end
    #1;
    check("t1_empty_wvalid", m_wvalid, 0);
    check("t1_empty_wdata", m_wdata, 0);
    check("t1_empty_wready", wready, 0);
    wvalid = 2'b00; wlast = 2'b00;

    // ---- 2: port1 len=3 then port0 len=0; W stays ordered ----
    @(negedge clk); awvalid = 2'b10; awlen = {8'd3, 8'd0}; #1;
    check("t2_grant1", awready, 2'b10);
    @(negedge clk); awvalid = 2'b01; #1;
    check("t2_m_awlen", m_awlen, 3);
    check("t2_hold_no_grant", awready, 0);
    @(negedge clk); #1;
    check("t2_grant0", awready, 2'b01);
    @(negedge clk); awvalid = 2'b00; wvalid = 2'b11; wlast = 2'b01;
    wdata = {32'h0000_00D0, 32'h0000_00C0};
    for (int k = 0; k < 4; k++) begin
      wdata[63:32] = 32'hD0 + k;
      wlast[1] = (k == 3);
      #1;
      check("t2_w_data", m_wdata, 32'hD0 + k);
      check("t2_w_last", m_wlast, (k == 3));
      check("t2_wready0_low", wready, 2'b10);
      if (k == 1) begin
        m_wready = 1'b0; #1;
        check("t2_stall_wready", wready, 2'b00);
        check("t2_stall_wvalid", m_wvalid, 1);
        @(negedge clk); m_wready = 1'b1; #1;
        check("t2_stall_hold", m_wdata, 32'hD1);
      end
      @(negedge clk);
    end
    #1;
    check("t2_port0_data", m_wdata, 32'hC0);
    check("t2_port0_wready", wready, 2'b01);
    check("t2_port0_last", m_wlast, 1);
    @(negedge clk); #1;
    check("t2_empty", m_wvalid, 0);
    wvalid = 2'b00; wlast = 2'b00;

    // ---- 3: FIFO full blocks the 5th grant; pop lets it through one cycle later ----
    @(negedge clk); awvalid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t3_grant", awready, (i % 2) ? 2'b01 : 2'b10);
      @(negedge clk); @(negedge clk);
    end
    #1;
    check("t3_full_block", awready, 0);
    @(negedge clk); #1;
    check("t3_full_block2", awready, 0);
    wvalid = 2'b10; wlast = 2'b10; wdata[63:32] = 32'hF1; #1;
    check("t3_pop_wvalid", m_wvalid, 1);
    check("t3_pop_data", m_wdata, 32'hF1);
    check("t3_no_same_cycle_push", awready, 0);
    @(negedge clk); wvalid = 2'b00; #1;
    check("t3_grant_after_pop", awready, 2'b10);
    @(negedge clk); awvalid = 2'b00; wvalid = 2'b11; wlast = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t3_drain_wready", wready, (i % 2) ? 2'b10 : 2'b01);
      @(negedge clk);
    end
    #1;
    check("t3_drained", m_wvalid, 0);
    wvalid = 2'b00; wlast = 2'b00;

    // ---- 4: W passes while AW is still held downstream ----
    @(negedge clk); m_awready = 1'b0; awvalid = 2'b01; #1;
    check("t4_grant", awready, 2'b01);
    @(negedge clk); awvalid = 2'b00; wvalid = 2'b01; wlast = 2'b01; wdata[31:0] = 32'hE0; #1;
    check("t4_w_before_aw", m_wdata, 32'hE0);
    check("t4_w_valid", m_wvalid, 1);
    check("t4_w_user", m_wuser, 2'b10);
    check("t4_aw_held", m_awvalid, 1);
    @(negedge clk); wvalid = 2'b00; #1;
    check("t4_popped", m_wvalid, 0);
    check("t4_aw_still_held", m_awvalid, 1);
    repeat (2) @(negedge clk);
    #1;
    check("t4_aw_held_late", m_awvalid, 1);
    @(negedge clk); m_awready = 1'b1; #1;
    check("t4_aw_before_accept", m_awvalid, 1);
    @(negedge clk); #1;
    check("t4_aw_accepted", m_awvalid, 0);

    // ---- 5: reset mid-burst ----
    @(negedge clk); awvalid = 2'b10; awlen = {8'd3, 8'd0}; #1;
    check("t5_grant1", awready, 2'b10);
    @(negedge clk); awvalid = 2'b00; wvalid = 2'b10; wlast = 2'b00; wdata[63:32] = 32'h51; #1;
    check("t5_beat1", m_wdata, 32'h51);
    @(negedge clk); wdata[63:32] = 32'h52; #1;
    check("t5_beat2", m_wdata, 32'h52);
    awvalid = 2'b11; rst = 1'b1; #1;
    check("t5_rst_wvalid", m_wvalid, 0);
    check("t5_rst_wdata", m_wdata, 0);
    check("t5_rst_wready", wready, 0);
    check("t5_rst_awvalid", m_awvalid, 0);
    check("t5_rst_awready", awready, 0);
    check("t5_rst_awaddr", m_awaddr, 0);
    @(negedge clk); #1;
    check("t5_rst_hold_wvalid", m_wvalid, 0);
    rst = 1'b0; wvalid = 2'b00; #1;
    check("t5_first_grant_port0", awready, 2'b01);
    @(negedge clk); #1;
    check("t5_m_awid", m_awid, 4'h3);
    check("t5_m_awvalid", m_awvalid, 1);

`ifdef AXI4_WARB_STATS_EN
    // ---- 6: grant counters ----
    @(negedge clk); awvalid = 2'b00; stats_clr = 1'b1;
    @(negedge clk); stats_clr = 1'b0; #1;
    check("t6_clr_cnt0", grant_cnt0, 0);
    check("t6_clr_cnt1", grant_cnt1, 0);
    wvalid = 2'b11; wlast = 2'b11; m_wready = 1'b1;
    for (int c = 0; c < 60 && granted < 10; c++) begin
      awvalid = (granted < 8) ? 2'b11 : 2'b01;
      #1;
      if (awready != 2'b00) granted++;
      @(negedge clk);
    end
    awvalid = 2'b00;
    check("t6_grants_done", granted, 10);
    repeat (2) @(negedge clk);
    #1;
    check("t6_cnt0", grant_cnt0, 6);
    check("t6_cnt1", grant_cnt1, 4);
    awvalid = 2'b01;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (awready != 2'b00) begin
        stats_clr = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk); stats_clr = 1'b0; awvalid = 2'b00; #1;
    check("t6_clr_beats_grant", grant_cnt0, 0);
    wvalid = 2'b00; wlast = 2'b00;
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
